// File: rtl/split_access_lsu.sv
// Load/store unit: valid/ready request from the core, request/grant data bus,
// splitting of beat-crossing accesses into two aligned beats, and a store-only print port.
module split_access_lsu #(
  parameter int                XLEN           = 32,
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] PRINT_ADDR     = 32'hFFFF_FFF0,
  parameter bit                MISALIGN_SPLIT = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_fault,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_wstrb,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_err,
  output logic                print_en,
  output logic [31:0]         print_data
);

  localparam int B     = XLEN / 8;
  localparam int OFF_W = $clog2(B);
  localparam int W2    = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state, state_nx;

  logic             lat_we, lat_uns, lat_split, lat_print, beat;
  logic [OFF_W-1:0] lat_off;
  logic [1:0]       lat_size;
  logic [XLEN-1:0]  lat_wdata, rdata0;

  logic [OFF_W-1:0] req_off;
  logic             req_split, imm_fault, is_print, accept;
  logic [W2-1:0]    win;
  logic [XLEN-1:0]  load_merge;

  function automatic logic is_split(input logic [OFF_W-1:0] off, input logic [1:0] size);
    return (int'(off) + (1 << size)) > B;
  endfunction

  // Byte strobes of one beat; hi selects the second beat of a split access.
  function automatic logic [B-1:0] lane_mask(input logic [OFF_W-1:0] off, input logic [1:0] size,
                                              input logic hi);
    logic [2*B-1:0] m;
    int lo, top;
    lo  = int'(off);
    top = lo + (1 << size);
    m   = '0;
    for (int i = 0; i < 2 * B; i++) m[i] = (i >= lo) && (i < top);
    return hi ? m[2*B-1:B] : m[B-1:0];
  endfunction

  function automatic logic [XLEN-1:0] lane_data(input logic [XLEN-1:0] d, input logic [OFF_W-1:0] off,
                                                 input logic hi);
    logic [W2-1:0] w;
    w = {{XLEN{1'b0}}, d} << {off, 3'b000};
    return hi ? w[W2-1:XLEN] : w[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [W2-1:0] w, input logic [OFF_W-1:0] off,
                                                   input logic [1:0] size, input logic uns);
    logic [W2-1:0]   s;
    logic [XLEN-1:0] r;
    logic            top;
    int              nb;
    s  = w >> {off, 3'b000};
    nb = 8 << size;
    case (size)
      2'd0:    top = s[7];
      2'd1:    top = s[15];
      2'd2:    top = s[31];
      default: top = 1'b0;
    endcase
    top = top & ~uns;
    r   = s[XLEN-1:0];
    for (int i = 0; i < XLEN; i++) if (i >= nb) r[i] = top;
    return r;
  endfunction

  assign req_off   = req_addr[OFF_W-1:0];
  assign req_split = is_split(req_off, req_size);
  assign imm_fault = ((req_size == 2'd3) && (XLEN == 32)) || (req_split && !MISALIGN_SPLIT);
  assign is_print  = req_we && (req_addr == PRINT_ADDR);
  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  assign mem_req   = (state == ISSUE);
  assign rsp_valid = (state == RESP);
  assign print_en  = (state == RESP) && lat_print;

  // Two-beat window: the second beat's bytes sit above the first beat's.
  assign win        = lat_split ? {mem_rdata, rdata0} : {{XLEN{1'b0}}, mem_rdata};
  assign load_merge = load_extend(win, lat_off, lat_size, lat_uns);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (imm_fault || is_print) ? RESP : ISSUE;
      ISSUE:   if (mem_gnt) state_nx = WAIT;
      WAIT:    if (mem_rvalid) state_nx = (!mem_err && lat_split && !beat) ? ISSUE : RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= '0;
      mem_wdata  <= '0;
      rsp_rdata  <= '0;
      rsp_fault  <= 1'b0;
      print_data <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          lat_we    <= req_we;
          lat_off   <= req_off;
          lat_size  <= req_size;
          lat_uns   <= req_unsigned;
          lat_split <= req_split;
          lat_print <= is_print && !imm_fault;
          lat_wdata <= req_wdata;
          beat      <= 1'b0;
          mem_we    <= req_we;
          mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          mem_wstrb <= req_we ? lane_mask(req_off, req_size, 1'b0) : '0;
          mem_wdata <= lane_data(req_wdata, req_off, 1'b0);
          rsp_fault <= imm_fault;
          rsp_rdata <= '0;
          if (is_print && !imm_fault) print_data <= req_wdata[31:0];
        end
        WAIT: if (mem_rvalid) begin
          if (mem_err) begin
            rsp_fault <= 1'b1;
            rsp_rdata <= '0;
          end else if (lat_split && !beat) begin
            rdata0    <= mem_rdata;
            beat      <= 1'b1;
            mem_addr  <= mem_addr + ADDR_W'(B);
            mem_wstrb <= lat_we ? lane_mask(lat_off, lat_size, 1'b1) : '0;
            mem_wdata <= lane_data(lat_wdata, lat_off, 1'b1);
          end else begin
            rsp_fault <= 1'b0;
            rsp_rdata <= lat_we ? '0 : load_merge;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_split_access_lsu.sv
// Directed bench for split_access_lsu (XLEN=32): scoreboard of expected responses,
// a scripted bus responder, and a second instance with beat-crossing splits disabled.
module tb_split_access_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        print_en;
  logic [31:0] print_data;

  logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [1:0]  b_req_size;
  logic        b_rsp_valid, b_rsp_fault, b_mem_req, b_mem_we, b_print_en;
  logic [31:0] b_rsp_rdata, b_mem_addr, b_mem_wdata, b_print_data;
  logic [3:0]  b_mem_wstrb;

  always #5 clk = ~clk;

  split_access_lsu #(.XLEN(32), .ADDR_W(32), .PRINT_ADDR(32'hFFFF_FFF0), .MISALIGN_SPLIT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err),
    .print_en(print_en), .print_data(print_data)
  );

  split_access_lsu #(.XLEN(32), .ADDR_W(32), .PRINT_ADDR(32'hFFFF_FFF0), .MISALIGN_SPLIT(1'b0)) dut_nosplit (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .req_size(b_req_size), .req_unsigned(b_req_unsigned),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_fault(b_rsp_fault),
    .mem_req(b_mem_req), .mem_gnt(1'b0), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wstrb(b_mem_wstrb), .mem_wdata(b_mem_wdata), .mem_rvalid(1'b0),
    .mem_rdata(32'h0), .mem_err(1'b0),
    .print_en(b_print_en), .print_data(b_print_data)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic        pr;
    logic [31:0] pdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   acc_cycle = 0;

  function automatic exp_t mk(input logic [31:0] rdata, input logic fault, input logic pr,
                              input logic [31:0] pdata);
    exp_t e;
    e.rdata = rdata;
    e.fault = fault;
    e.pr    = pr;
    e.pdata = pdata;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic request(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input exp_t e, input logic expect_rsp);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    check("req_ready_before_accept", req_ready, 1);
    cyc();
    acc_cycle = cycle;
    req_valid = 1'b0;
    if (expect_rsp) sb.push_back(e);
  endtask

  task automatic bus_beat(input string tag, input logic [31:0] addr, input logic we,
                          input logic [3:0] strb, input logic [31:0] wdata, input int stall,
                          input int rwait, input logic [31:0] rdata, input logic err);
    int n = 0;
    while (!mem_req && n < 10) begin cyc(); n++; end
    check({tag, "_req"}, mem_req, 1);
    check({tag, "_addr"}, mem_addr, addr);
    check({tag, "_we"}, mem_we, we);
    if (we) begin
      check({tag, "_wstrb"}, mem_wstrb, strb);
      check({tag, "_wdata"}, mem_wdata, wdata);
    end
    for (int i = 0; i < stall; i++) begin
      cyc();
      check({tag, "_stall_req"}, mem_req, 1);
      check({tag, "_stall_addr"}, mem_addr, addr);
      check({tag, "_stall_wstrb"}, mem_wstrb, strb);
      check({tag, "_stall_wdata"}, mem_wdata, wdata);
    end
    mem_gnt = 1'b1;
    cyc();
    mem_gnt = 1'b0;
    check({tag, "_req_drop"}, mem_req, 0);
    for (int i = 0; i < rwait; i++) cyc();
    mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = err;
    cyc();
    mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int lat);
    int   n = 0;
    exp_t e;
    while (!rsp_valid && n < 20) begin cyc(); n++; end
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_rdata"}, rsp_rdata, e.rdata);
      check({tag, "_fault"}, rsp_fault, e.fault);
      check({tag, "_print_en"}, print_en, e.pr);
      if (e.pr) check({tag, "_print_data"}, print_data, e.pdata);
    end
    check({tag, "_latency"}, cycle - acc_cycle + 1, lat);
    check({tag, "_ready_in_rsp"}, req_ready, 0);
    cyc();
    check({tag, "_rsp_pulse"}, rsp_valid, 0);
    check({tag, "_print_pulse"}, print_en, 0);
    check({tag, "_ready_after"}, req_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_size = '0; req_unsigned = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; mem_err = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0; b_req_size = '0; b_req_unsigned = 0;
    cyc();
    cyc();

    // reset state
    check("rst_req_ready", req_ready, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_fault", rsp_fault, 0);
    check("rst_print_en", print_en, 0);
    check("rst_print_data", print_data, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", req_ready, 1);

    // aligned word load
    request(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, mk(32'hDEADBEEF, 0, 0, 0), 1'b1);
    bus_beat("lw", 32'h100, 1'b0, 4'h0, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0);
    wait_rsp("lw", 3);

    // byte/half extraction within one beat
    request(1'b0, 32'h103, 32'h0, 2'd0, 1'b0, mk(32'hFFFFFF80, 0, 0, 0), 1'b1);
    bus_beat("lb", 32'h100, 1'b0, 4'h0, 32'h0, 0, 0, 32'h80123456, 1'b0);
    wait_rsp("lb", 3);
    request(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, mk(32'h00000080, 0, 0, 0), 1'b1);
    bus_beat("lbu", 32'h100, 1'b0, 4'h0, 32'h0, 0, 1, 32'h80123456, 1'b0);
    wait_rsp("lbu", 4);
    request(1'b0, 32'h101, 32'h0, 2'd1, 1'b0, mk(32'h00001234, 0, 0, 0), 1'b1);
    bus_beat("lh", 32'h100, 1'b0, 4'h0, 32'h0, 0, 0, 32'h80123456, 1'b0);
    wait_rsp("lh", 3);

    // split word load across two beats
    request(1'b0, 32'h102, 32'h0, 2'd2, 1'b0, mk(32'h66554433, 0, 0, 0), 1'b1);
    bus_beat("slw_b0", 32'h100, 1'b0, 4'h0, 32'h0, 0, 0, 32'h44332211, 1'b0);
    bus_beat("slw_b1", 32'h104, 1'b0, 4'h0, 32'h0, 0, 0, 32'h88776655, 1'b0);
    wait_rsp("slw", 5);

    // split word store with a stalled grant on beat 0
    request(1'b1, 32'h103, 32'hAABBCCDD, 2'd2, 1'b0, mk(32'h0, 0, 0, 0), 1'b1);
    bus_beat("ssw_b0", 32'h100, 1'b1, 4'b1000, 32'hDD000000, 3, 0, 32'h0, 1'b0);
    bus_beat("ssw_b1", 32'h104, 1'b1, 4'b0111, 32'h00AABBCC, 0, 0, 32'h0, 1'b0);
    wait_rsp("ssw", 8);

    // bus error on beat 0 of a split load: no second beat
    request(1'b0, 32'h0FE, 32'h0, 2'd2, 1'b0, mk(32'h0, 1, 0, 0), 1'b1);
    bus_beat("err_b0", 32'h0FC, 1'b0, 4'h0, 32'h0, 0, 0, 32'h12345678, 1'b1);
    check("err_no_beat1", mem_req, 0);
    wait_rsp("err", 3);
    check("err_no_beat1_late", mem_req, 0);

    // dword on a 32-bit unit faults without bus traffic
    request(1'b0, 32'h100, 32'h0, 2'd3, 1'b0, mk(32'h0, 1, 0, 0), 1'b1);
    check("ld_no_req", mem_req, 0);
    wait_rsp("ld", 1);

    // split access with splitting disabled faults
    b_req_valid = 1'b1; b_req_addr = 32'h102; b_req_size = 2'd2; b_req_we = 1'b0;
    check("ns_ready", b_req_ready, 1);
    cyc();
    b_req_valid = 1'b0;
    check("ns_rsp_valid", b_rsp_valid, 1);
    check("ns_fault", b_rsp_fault, 1);
    check("ns_rdata", b_rsp_rdata, 0);
    check("ns_no_req", b_mem_req, 0);
    cyc();
    check("ns_rsp_pulse", b_rsp_valid, 0);

    // print port
    request(1'b1, 32'hFFFFFFF0, 32'h00004242, 2'd2, 1'b0, mk(32'h0, 0, 1, 32'h00004242), 1'b1);
    check("print_no_req", mem_req, 0);
    wait_rsp("print", 1);

    // reset during WAIT; a late response must not complete anything
    request(1'b0, 32'h200, 32'h0, 2'd2, 1'b0, mk(32'h0, 0, 0, 0), 1'b0);
    check("abort_req", mem_req, 1);
    mem_gnt = 1'b1;
    cyc();
    mem_gnt = 1'b0;
    check("abort_wait_req", mem_req, 0);
    rst = 1'b1;
    cyc();
    check("abort_mem_req", mem_req, 0);
    check("abort_ready_in_rst", req_ready, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    #1;
    check("abort_idle", req_ready, 1);
    cyc();
    mem_rvalid = 1'b0; mem_rdata = '0;
    check("abort_late_rvalid", rsp_valid, 0);
    cyc();
    check("abort_late_rvalid2", rsp_valid, 0);

    // reset while the request is still waiting for a grant
    request(1'b0, 32'h204, 32'h0, 2'd2, 1'b0, mk(32'h0, 0, 0, 0), 1'b0);
    check("abort2_req", mem_req, 1);
    rst = 1'b1;
    cyc();
    check("abort2_mem_req", mem_req, 0);
    rst = 1'b0;
    cyc();
    check("abort2_no_rsp", rsp_valid, 0);

    // normal traffic resumes
    request(1'b0, 32'h300, 32'h0, 2'd1, 1'b0, mk(32'hFFFF8765, 0, 0, 0), 1'b1);
    bus_beat("post", 32'h300, 1'b0, 4'h0, 32'h0, 0, 0, 32'h12348765, 1'b0);
    wait_rsp("post", 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
